// File: rtl/tt_if.sv
// tt_if: Tiny Tapeout style pin bundle shared by the count checker and its driver.
interface tt_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: lock/slip checker for a free-running 4-bit up counter with a saturating error count.
module tt_um_count_checker #(
   parameter int LOCK_MATCHES = 4
) (
   input logic clk,
   input logic rst_n,
   tt_if.slave io
);
   localparam logic [1:0] SEARCH = 2'b00;
   localparam logic [1:0] LOCKED = 2'b01;
   localparam logic [1:0] SLIP   = 2'b10;
   logic [1:0] state, st, state_d;
   logic [3:0] expected, expected_d, match_cnt, match_d, sample;
   logic [7:0] err_cnt, err_d;
   logic       have_prev, have_prev_d, sticky, sticky_d;
   logic       valid, clr, hit, lock_hit, err_ev;
   logic       unused_ok;
   assign sample    = io.ui_in[3:0];
   assign valid     = io.ui_in[4];
   assign clr       = io.ui_in[5];
   assign unused_ok = &{1'b0, io.ena, io.ui_in[7:6], io.uio_in};
   // the unreachable code 11 behaves as SEARCH everywhere, including the outputs
   assign st        = state == 2'b11 ? SEARCH : state;
   assign hit       = sample == expected;
   assign lock_hit  = {1'b0, match_cnt} + 5'd1 == 5'(LOCK_MATCHES);
   always_comb begin
      state_d     = st;
      expected_d  = expected;
      match_d     = match_cnt;
      have_prev_d = have_prev;
      err_ev      = 1'b0;
      if (valid) begin
         case (st)
            LOCKED: begin
               if (hit) expected_d = sample + 4'd1;
               else begin
                  state_d    = SLIP;
                  expected_d = expected + 4'd1;
                  err_ev     = 1'b1;
               end
            end
            SLIP: begin
               expected_d = sample + 4'd1;
               if (hit) state_d = LOCKED;
               else begin
                  state_d     = SEARCH;
                  have_prev_d = 1'b1;
                  match_d     = 4'd0;
               end
            end
            default: begin
               expected_d  = sample + 4'd1;
               have_prev_d = 1'b1;
               if (have_prev && hit && lock_hit) begin
                  state_d = LOCKED;
                  match_d = 4'd0;
               end else if (have_prev) match_d = hit ? match_cnt + 4'd1 : 4'd0;
            end
         endcase
      end
      err_d    = clr ? 8'd0 : (err_ev && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
      sticky_d = clr ? 1'b0 : sticky | err_ev;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEARCH;
         expected  <= 4'd0;
         match_cnt <= 4'd0;
         have_prev <= 1'b0;
         err_cnt   <= 8'd0;
         sticky    <= 1'b0;
      end else begin
         state     <= state_d;
         expected  <= expected_d;
         match_cnt <= match_d;
         have_prev <= have_prev_d;
         err_cnt   <= err_d;
         sticky    <= sticky_d;
      end
   end
   assign io.uo_out  = err_cnt;
   assign io.uio_out = {expected, sticky, st == LOCKED, st};
   assign io.uio_oe  = 8'hFF;
endmodule
